label_bitmap_packer: RTL and testbench
======================================

Name: label_bitmap_packer

Overview:
- Reads the 32x32 label map that the CLE writes into the 1024x8 SRAM and re-packs it into the 128-byte, 1-bit-per-pixel bitmap format used by the image ROM.
- Bits are selected by label: all nonzero labels, or one chosen label.
- Sits behind the SRAM read port, after CLE asserts finish.
- Emits bytes on a valid/ready stream for round-trip checks against the source ROM image and for per-object mask extraction.

Parameters:
- IMG_W, 32, image width/height in pixels
- PIX_N, 1024, pixels per image (IMG_W*IMG_W)
- BYTE_N, 128, packed output bytes (PIX_N/8)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a pack pass when idle
- sel_label  in  8  0 = any nonzero label, else exact label match; latched on accepted start
- sram_q  in  8  SRAM read data, valid the cycle after sram_a is presented
- sram_a  out  10  SRAM address, pixel index row*32+col
- sram_wen  out  1  held 1 (read only)
- out_valid  out  1  packed byte available
- out_ready  in  1  consumer accepts when out_valid&&out_ready at posedge
- out_data  out  8  packed byte; bit7 = lowest-index pixel of the group of 8
- out_addr  out  7  byte index 0..127 of out_data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final handshake
- pix_cnt  out  11  matching-pixel count of the current/last pass (0..1024)

Behaviour:
- Reset: state IDLE; sram_a=0, sram_wen=1, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, pix_cnt=0. Reset mid-pass aborts immediately; no further SRAM reads and no out_valid.
- States:
  - IDLE: start -> READ, with byte index=0, pix_cnt=0, sel latched.
  - READ: 9 cycles per byte. sram_a = byte*8+k for k=0..7 on cycles 0..7. sram_q is sampled on cycles 1..8 into an MSB-first shift register.
  - EMIT: out_valid=1 until handshake. On handshake: if byte==127 -> DONE, else byte+1 -> READ.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Match rule: sel_label==0 matches sram_q!=0; otherwise matches sram_q==sel_label. Each match sets the bit and increments pix_cnt.
- Stream rules:
  - out_data/out_addr stable while out_valid&&!out_ready.
  - out_valid never drops without a handshake.
  - sram_a does not advance during EMIT.
- Latency: minimum 10 cycles per byte with out_ready high; pass = 1280 cycles start->done (+1 for the done pulse).
- Boundaries:
  - start while busy is ignored.
  - start in the same cycle as done is ignored.
  - sel_label changes mid-pass have no effect.
  - pix_cnt saturates naturally at 1024 (11 bits, no wrap).
  - pix_cnt holds its value after done until the next accepted start.

Optional Feature:
- PACK_CRC_EN defined: extra output crc 8 bits. CRC-8, poly 0x07, init 0x00, MSB first, updated on each handshake byte. Cleared on accepted start and on reset. Valid when done pulses.
- PACK_CRC_EN undefined: no crc port and no CRC logic.

Decomposition:
- Package label_pack_pkg holds:
  - constants IMG_W, PIX_N, BYTE_N
  - state enum {IDLE, READ, EMIT, DONE}
  - CRC8 polynomial constant
- One sub-module, crc8_step: combinational byte-wise CRC-8 update, instantiated only under PACK_CRC_EN.

Test Plan:
- SRAM all 0x00, sel=0, out_ready=1 -> 128 bytes 0x00, out_addr 0..127 in order, pix_cnt=0, done at cycle 1281 after start.
- SRAM[0]=1, SRAM[7]=1, SRAM[1023]=2, sel=0 -> byte0=0x81, byte127=0x01, others 0x00, pix_cnt=3.
- Same SRAM, sel=2 -> byte0=0x00, byte127=0x01, pix_cnt=1. With PACK_CRC_EN, crc equals CRC-8 of that 128-byte stream.
- out_ready held low 5 cycles while byte 3 is valid -> out_data/out_addr/sram_a unchanged, out_valid stays 1, byte 4 reads start after the handshake.
- reset pulsed during byte 50 -> next cycle all outputs at reset values. A new start yields a full 128-byte pass, pix_cnt counted from 0.
- Round trip: run CLE on the ROM image, then pack with sel=0 -> 128 bytes equal the ROM contents exactly.

Source files
------------

// File: rtl/label_bitmap_packer_pkg.sv
// Shared constants and state encoding for the label bitmap packer.
// Included by every packer file via import label_pack_pkg::*.
package label_pack_pkg;

    localparam int IMG_W  = 32;
    localparam int PIX_N  = IMG_W * IMG_W;
    localparam int BYTE_N = PIX_N / 8;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EMIT,
        DONE
    } pack_state_e;

endpackage

// File: rtl/label_bitmap_packer_if.sv
// SRAM read port and packed-byte stream of the label bitmap packer.
// master = packer side, slave = SRAM/consumer side.
interface label_bitmap_packer_if;

    logic [9:0] sram_a;
    logic       sram_wen;
    logic [7:0] sram_q;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] out_addr;

    modport master (
        output sram_a, sram_wen,
        output out_valid, out_data, out_addr,
        input  sram_q, out_ready
    );

    modport slave (
        input  sram_a, sram_wen,
        input  out_valid, out_data, out_addr,
        output sram_q, out_ready
    );

endinterface

// File: rtl/label_bitmap_packer_crc8.sv
// Byte-wise CRC-8 update, MSB first, polynomial from the package.
// Pure combinational; the caller holds the running register.
module crc8_step
    import label_pack_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/label_bitmap_packer.sv
// Re-packs the 32x32 label map in SRAM into a 128-byte 1bpp bitmap stream.
// Define PACK_CRC_EN to add a running CRC-8 of the emitted bytes on port crc.
module label_bitmap_packer
    import label_pack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  sel_label,
    label_bitmap_packer_if.master bus,
    output logic        busy,
    output logic        done,
`ifdef PACK_CRC_EN
    output logic [7:0]  crc,
`endif
    output logic [10:0] pix_cnt
);

    pack_state_e state_q, state_d;

    logic [6:0]  byte_idx;
    logic [3:0]  rd_cnt;
    logic [7:0]  shift_q;
    logic [7:0]  sel_q;
    logic [7:0]  data_q;
    logic [10:0] pix_cnt_q;
    logic [2:0]  rd_k;
    logic        start_ok;
    logic        hs;
    logic        sample;
    logic        rd_last;
    logic        match;

    assign start_ok = (state_q == IDLE) && start;
    assign hs       = (state_q == EMIT) && bus.out_ready;
    assign sample   = (state_q == READ) && (rd_cnt != 4'd0);
    assign rd_last  = (rd_cnt == 4'd8);
    assign match    = (sel_q == 8'd0) ? (bus.sram_q != 8'd0)
                                      : (bus.sram_q == sel_q);

    // Address pins at the group's last pixel while the final read lands
    // and while the byte waits for its handshake.
    assign rd_k = rd_cnt[3] ? 3'd7 : rd_cnt[2:0];

    assign bus.sram_a    = {byte_idx, rd_k};
    assign bus.sram_wen  = 1'b1;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = data_q;
    assign bus.out_addr  = byte_idx;

    assign busy    = (state_q == READ) || (state_q == EMIT);
    assign done    = (state_q == DONE);
    assign pix_cnt = pix_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = READ;
            READ: if (rd_last) state_d = EMIT;
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = (byte_idx == 7'(BYTE_N - 1)) ? DONE : READ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx  <= '0;
            rd_cnt    <= '0;
            shift_q   <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            pix_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                byte_idx  <= '0;
                rd_cnt    <= '0;
                pix_cnt_q <= '0;
                sel_q     <= sel_label;
            end
            if (state_q == READ) begin
                if (!rd_last) rd_cnt <= rd_cnt + 4'd1;
                if (sample) begin
                    shift_q   <= {shift_q[6:0], match};
                    pix_cnt_q <= pix_cnt_q + 11'(match);
                end
                if (rd_last) data_q <= {shift_q[6:0], match};
            end
            if (hs) begin
                rd_cnt <= '0;
                if (byte_idx != 7'(BYTE_N - 1)) begin
                    byte_idx <= byte_idx + 7'd1;
                end
            end
        end
    end

`ifdef PACK_CRC_EN
    logic [7:0] crc_q, crc_nx;

    crc8_step u_crc (
        .crc_in  (crc_q),
        .data    (data_q),
        .crc_out (crc_nx)
    );

    always_ff @(posedge clk) begin
        if (reset)         crc_q <= '0;
        else if (start_ok) crc_q <= '0;
        else if (hs)       crc_q <= crc_nx;
    end

    assign crc = crc_q;
`endif

endmodule

// File: tb/tb_label_bitmap_packer.sv
// Randomized self-checking bench for label_bitmap_packer.
// Expected bitmap, pixel count and CRC come from a pixel-level model.
module tb_label_bitmap_packer;
    import label_pack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  sel_label;
    logic        busy;
    logic        done;
    logic [10:0] pix_cnt;
`ifdef PACK_CRC_EN
    logic [7:0]  crc;
`endif

    label_bitmap_packer_if bus ();

    label_bitmap_packer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sel_label (sel_label),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
`ifdef PACK_CRC_EN
        .crc       (crc),
`endif
        .pix_cnt   (pix_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [PIX_N];

    always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_b [BYTE_N];
    int         exp_pc;
    logic [7:0] exp_crc;

    function automatic logic [7:0] crc_ref(input logic [7:0] c,
                                           input logic [7:0] d);
        logic [15:0] r;
        r = {c ^ d, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic model(input logic [7:0] sel);
        exp_pc  = 0;
        exp_crc = 8'h00;
        for (int p = 0; p < PIX_N; p++) begin
            bit hit;
            hit = (sel == 0) ? (mem[p] != 0) : (mem[p] == sel);
            if (p % 8 == 0) exp_b[p / 8] = 8'h00;
            if (hit) begin
                exp_b[p / 8][7 - (p % 8)] = 1'b1;
                exp_pc++;
            end
        end
        for (int b = 0; b < BYTE_N; b++) exp_crc = crc_ref(exp_crc, exp_b[b]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sram_a"}, bus.sram_a, 0);
        chk({tag, "_wen"}, bus.sram_wen, 1);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_addr"}, bus.out_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pix"}, pix_cnt, 0);
`ifdef PACK_CRC_EN
        chk({tag, "_crc"}, crc, 0);
`endif
    endtask

    // mode 0: ready always high; 1: random ready plus noise on start/sel;
    // 2: ready held low for 5 cycles while byte 3 is offered
    task automatic run_pass(input logic [7:0] sel, input int mode);
        int n, idx, stall_n, ph;
        bit got_done, prev_stall, prev_hs;
        logic [7:0] pd;
        logic [6:0] pa;
        logic [9:0] psa;
        bit hsn;
        model(sel);
        @(negedge clk);
        sel_label     = sel;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; idx = 0; stall_n = 0; ph = 0;
        got_done = 0; prev_stall = 0; prev_hs = 0;
        pd = '0; pa = '0; psa = '0;
        while (!got_done && n < 20000) begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, pd);
                chk("hold_addr", bus.out_addr, pa);
                chk("hold_sram_a", bus.sram_a, psa);
            end
            if (prev_hs && ph < BYTE_N - 1) chk("next_rd_a", bus.sram_a, (ph + 1) * 8);
            prev_hs = 0;
            if (done) begin
                got_done = 1;
                chk("byte_count", idx, BYTE_N);
                chk("pix_cnt", pix_cnt, exp_pc);
                chk("busy_at_done", busy, 0);
                if (mode == 0) chk("latency", n, 1281);
`ifdef PACK_CRC_EN
                chk("crc", crc, exp_crc);
`endif
                start = 1'b1;
            end else begin
                start = 1'b0;
                chk("busy", busy, 1);
                case (mode)
                    1: bus.out_ready = ($urandom % 3) != 0;
                    2: begin
                        if (bus.out_valid && bus.out_addr == 7'd3 && stall_n < 5) begin
                            bus.out_ready = 1'b0;
                            stall_n++;
                        end else begin
                            bus.out_ready = 1'b1;
                        end
                    end
                    default: bus.out_ready = 1'b1;
                endcase
                if (mode == 1) begin
                    sel_label = 8'($urandom);
                    start     = ($urandom % 40) == 0;
                end
                hsn = bus.out_valid && bus.out_ready;
                if (hsn) begin
                    if (idx < BYTE_N) begin
                        chk("data", bus.out_data, exp_b[idx]);
                        chk("addr", bus.out_addr, idx);
                    end
                    idx++;
                    ph = bus.out_addr;
                    prev_hs = 1;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                pd  = bus.out_data;
                pa  = bus.out_addr;
                psa = bus.sram_a;
            end
            @(negedge clk);
            n++;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        start = 1'b0;
        if (mode == 2) chk("stall_cycles", stall_n, 5);
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("pix_hold", pix_cnt, exp_pc);
    endtask

    task automatic reset_mid_pass();
        int n, vcnt;
        @(negedge clk);
        sel_label     = 8'd0;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bus.sram_a < 10'd400 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte50", bus.sram_a[9:3], 50);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid || busy || bus.sram_a != 0) vcnt++;
        end
        chk("quiet_after_rst", vcnt, 0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        sel_label     = 8'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < PIX_N; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;

        run_pass(8'd0, 0);

        mem[0]    = 8'd1;
        mem[7]    = 8'd1;
        mem[1023] = 8'd2;
        run_pass(8'd0, 0);
        run_pass(8'd2, 0);
        run_pass(8'd0, 2);

        for (int i = 0; i < PIX_N; i++) mem[i] = 8'($urandom);
        reset_mid_pass();
        run_pass(8'd0, 0);

        for (int i = 0; i < PIX_N; i++) mem[i] = 8'd7;
        run_pass(8'd0, 0);

        for (int r = 0; r < 6; r++) begin
            logic [7:0] s;
            for (int i = 0; i < PIX_N; i++) begin
                case ($urandom % 4)
                    0, 1: mem[i] = 8'd0;
                    2:    mem[i] = 8'($urandom_range(1, 3));
                    default: mem[i] = 8'($urandom);
                endcase
            end
            case (r % 3)
                0: s = 8'd0;
                1: s = 8'($urandom_range(1, 3));
                default: s = 8'($urandom);
            endcase
            run_pass(s, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
